// File: rtl/cc_completer.sv
// Completer-completion generator: turns one MemRd request from the CQ path into a
// single-beat UltraScale CC completion, fetching up to 64 bits from the register file.
module cc_completer #(
  parameter int DATA_WIDTH     = 256,
  parameter int BAR0_SIZE      = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    user_clk,
  input  logic                    user_reset,
  input  logic                    cq_valid,
  input  logic [3:0]              cq_type,
  input  logic [BAR0_SIZE-1:0]    cq_reg_addr,
  input  logic [2:0]              cq_bar_id,
  input  logic [15:0]             cq_requester_id,
  input  logic [7:0]              cq_tag,
  input  logic [2:0]              cq_tc,
  input  logic [6:0]              cq_lower_addr,
  input  logic [10:0]             cq_payload_dw_count,
  output logic                    rd_req,
  output logic [BAR0_SIZE-1:0]    rd_addr,
  input  logic [63:0]             rd_data,
  input  logic                    rd_data_valid,
  output logic [DATA_WIDTH-1:0]   s_axis_cc_tdata,
  output logic [DATA_WIDTH/32-1:0] s_axis_cc_tkeep,
  output logic                    s_axis_cc_tlast,
  output logic [32:0]             s_axis_cc_tuser,
  output logic                    s_axis_cc_tvalid,
  input  logic                    s_axis_cc_tready,
  output logic                    busy,
  output logic [15:0]             drop_count
);

  localparam int KW = DATA_WIDTH / 32;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, SEND} state_t;

  state_t                r_state;
  logic [6:0]            r_lower_addr;
  logic                  r_addr2;
  logic [10:0]           r_dw;
  logic [15:0]           r_rid;
  logic [7:0]            r_tag;
  logic [2:0]            r_tc;
  logic [TW-1:0]         r_timer;
  logic                  r_rd_req;
  logic [BAR0_SIZE-1:0]  r_rd_addr;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic [KW-1:0]         r_tkeep;
  logic                  r_tvalid;
  logic [15:0]           r_drop_count;

  logic                  w_memrd;
  logic                  w_accept;
  logic                  w_ok;
  logic [6:0]            w_la;
  logic                  w_addr2;
  logic [10:0]           w_dw;
  logic [15:0]           w_rid;
  logic [7:0]            w_tag;
  logic [2:0]            w_tc;
  logic [2:0]            w_status;
  logic                  w_sc;
  logic [DATA_WIDTH-1:0] w_tdata;
  logic [KW-1:0]         w_tkeep;
  logic                  w_unused_addr;

  assign w_unused_addr = ^cq_reg_addr[1:0];
  assign w_memrd  = cq_valid && (cq_type == 4'b0000);
  assign w_accept = w_memrd && (r_state == IDLE);
  assign w_ok     = (cq_bar_id == 3'd0) &&
                    ((cq_payload_dw_count == 11'd1) ||
                     ((cq_payload_dw_count == 11'd2) && !cq_reg_addr[2]));

  // UR completions are built straight from the request inputs in IDLE;
  // read completions use the latched copy.
  always_comb begin
    w_la     = r_lower_addr;
    w_addr2  = r_addr2;
    w_dw     = r_dw;
    w_rid    = r_rid;
    w_tag    = r_tag;
    w_tc     = r_tc;
    w_status = rd_data_valid ? 3'b000 : 3'b100;
    if (r_state == IDLE) begin
      w_la     = cq_lower_addr;
      w_addr2  = cq_reg_addr[2];
      w_dw     = cq_payload_dw_count;
      w_rid    = cq_requester_id;
      w_tag    = cq_tag;
      w_tc     = cq_tc;
      w_status = 3'b001;
    end
    w_sc = (w_status == 3'b000);

    w_tdata        = '0;
    w_tdata[6:0]   = w_la;
    w_tdata[28:16] = w_sc ? {w_dw, 2'b00} : 13'd4;
    w_tdata[42:32] = w_sc ? w_dw : 11'd0;
    w_tdata[45:43] = w_status;
    w_tdata[63:48] = w_rid;
    w_tdata[71:64] = w_tag;
    w_tdata[91:89] = w_tc;
    w_tkeep        = KW'(8'h07);
    if (w_sc) begin
      if (w_dw == 11'd1) begin
        w_tdata[127:96] = w_addr2 ? rd_data[63:32] : rd_data[31:0];
        w_tkeep         = KW'(8'h0F);
      end else begin
        w_tdata[127:96]  = rd_data[31:0];
        w_tdata[159:128] = rd_data[63:32];
        w_tkeep          = KW'(8'h1F);
      end
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      r_state      <= IDLE;
      r_lower_addr <= '0;
      r_addr2      <= 1'b0;
      r_dw         <= '0;
      r_rid        <= '0;
      r_tag        <= '0;
      r_tc         <= '0;
      r_timer      <= '0;
      r_rd_req     <= 1'b0;
      r_rd_addr    <= '0;
      r_tdata      <= '0;
      r_tkeep      <= '0;
      r_tvalid     <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_rd_req <= 1'b0;
      if (w_memrd && (r_state != IDLE) && (r_drop_count != '1))
        r_drop_count <= r_drop_count + 16'd1;
      case (r_state)
        IDLE: if (w_accept) begin
          r_lower_addr <= cq_lower_addr;
          r_addr2      <= cq_reg_addr[2];
          r_dw         <= cq_payload_dw_count;
          r_rid        <= cq_requester_id;
          r_tag        <= cq_tag;
          r_tc         <= cq_tc;
          r_rd_addr    <= {cq_reg_addr[BAR0_SIZE-1:3], 3'b000};
          if (w_ok) begin
            r_rd_req <= 1'b1;
            r_state  <= RD_REQ;
          end else begin
            r_tdata  <= w_tdata;
            r_tkeep  <= w_tkeep;
            r_tvalid <= 1'b1;
            r_state  <= SEND;
          end
        end
        RD_REQ: begin
          r_timer <= '0;
          r_state <= RD_WAIT;
        end
        RD_WAIT: begin
          // Data arriving in the expiry cycle still produces a successful completion.
          if (rd_data_valid || (r_timer == TW'(TIMEOUT_CYCLES - 1))) begin
            r_tdata  <= w_tdata;
            r_tkeep  <= w_tkeep;
            r_tvalid <= 1'b1;
            r_state  <= SEND;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        SEND: if (s_axis_cc_tready) begin
          r_tvalid <= 1'b0;
          r_tdata  <= '0;
          r_tkeep  <= '0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rd_req           = r_rd_req;
  assign rd_addr          = r_rd_addr;
  assign s_axis_cc_tdata  = r_tdata;
  assign s_axis_cc_tkeep  = r_tkeep;
  assign s_axis_cc_tlast  = r_tvalid;
  assign s_axis_cc_tuser  = '0;
  assign s_axis_cc_tvalid = r_tvalid;
  assign busy             = (r_state != IDLE);
  assign drop_count       = r_drop_count;

endmodule

// File: tb/tb_cc_completer.sv
// Self-checking bench for cc_completer: directed vector table, random requests
// against a field-level completion model, and a reset-during-SEND sequence.
module tb_cc_completer;

  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         user_reset;
  logic         cq_valid;
  logic [3:0]   cq_type;
  logic [15:0]  cq_reg_addr;
  logic [2:0]   cq_bar_id;
  logic [15:0]  cq_requester_id;
  logic [7:0]   cq_tag;
  logic [2:0]   cq_tc;
  logic [6:0]   cq_lower_addr;
  logic [10:0]  cq_payload_dw_count;
  logic         rd_req;
  logic [15:0]  rd_addr;
  logic [63:0]  rd_data;
  logic         rd_data_valid;
  logic [255:0] s_axis_cc_tdata;
  logic [7:0]   s_axis_cc_tkeep;
  logic         s_axis_cc_tlast;
  logic [32:0]  s_axis_cc_tuser;
  logic         s_axis_cc_tvalid;
  logic         s_axis_cc_tready;
  logic         busy;
  logic [15:0]  drop_count;

  cc_completer #(.DATA_WIDTH(256), .BAR0_SIZE(16), .TIMEOUT_CYCLES(TO)) dut (
    .user_clk(clk), .user_reset(user_reset),
    .cq_valid(cq_valid), .cq_type(cq_type), .cq_reg_addr(cq_reg_addr),
    .cq_bar_id(cq_bar_id), .cq_requester_id(cq_requester_id), .cq_tag(cq_tag),
    .cq_tc(cq_tc), .cq_lower_addr(cq_lower_addr), .cq_payload_dw_count(cq_payload_dw_count),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .s_axis_cc_tdata(s_axis_cc_tdata), .s_axis_cc_tkeep(s_axis_cc_tkeep),
    .s_axis_cc_tlast(s_axis_cc_tlast), .s_axis_cc_tuser(s_axis_cc_tuser),
    .s_axis_cc_tvalid(s_axis_cc_tvalid), .s_axis_cc_tready(s_axis_cc_tready),
    .busy(busy), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int unsigned exp_drops = 0;

  typedef struct {
    logic [10:0] dw;  logic [15:0] addr; logic [2:0] bar; logic [15:0] rid;
    logic [7:0]  tag; logic [63:0] data; int unsigned lat; int unsigned hold;
    int unsigned drop_at; bit drop_send;
    logic [2:0]  e_status; logic [7:0] e_keep; logic [31:0] e_dw0;
  } vec_t;

  vec_t vt[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Completion contents derived from the request rules, independent of any FSM.
  task automatic model(input logic [10:0] dw, input logic [15:0] addr, input logic [2:0] bar,
                       input logic [15:0] rid, input logic [7:0] tag, input logic [2:0] tc,
                       input logic [6:0] la, input logic [63:0] data, input bit timed_out,
                       output logic [255:0] t, output logic [7:0] keep);
    bit ok;
    logic [2:0] st;
    logic [63:0] sh;
    int unsigned n;
    ok = (bar == 0) && (dw == 1 || (dw == 2 && addr[2] == 1'b0));
    st = !ok ? 3'b001 : (timed_out ? 3'b100 : 3'b000);
    n  = (st == 3'b000) ? int'(dw) : 0;
    t = '0;
    t[6:0]   = la;
    t[28:16] = (n != 0) ? 13'(n * 4) : 13'd4;
    t[42:32] = 11'(n);
    t[45:43] = st;
    t[63:48] = rid;
    t[71:64] = tag;
    t[91:89] = tc;
    for (int i = 0; i < int'(n); i++) begin
      sh = data >> (32 * (int'(addr[2]) + i));
      t[96 + 32 * i +: 32] = sh[31:0];
    end
    keep = (n != 0) ? 8'((1 << (3 + n)) - 1) : 8'h07;
  endtask

  task automatic do_req(input logic [10:0] dw, input logic [15:0] addr, input logic [2:0] bar,
                        input logic [15:0] rid, input logic [7:0] tag, input logic [2:0] tc,
                        input logic [6:0] la, input logic [63:0] data, input int unsigned lat,
                        input int unsigned hold, input int unsigned drop_at, input bit drop_send,
                        output logic [255:0] got, output logic [7:0] gk);
    bit ok, timed_out, stable;
    int unsigned exp_k, k, nrq, first_rq;
    logic [255:0] et;
    logic [7:0] ek;
    ok        = (bar == 0) && (dw == 1 || (dw == 2 && addr[2] == 1'b0));
    timed_out = ok && (lat > TO);
    exp_k     = !ok ? 1 : (timed_out ? 2 + TO : 2 + lat);
    model(dw, addr, bar, rid, tag, tc, la, data, timed_out, et, ek);
    got = '0; gk = '0;
    cq_valid = 1'b1; cq_type = 4'b0000; cq_reg_addr = addr; cq_bar_id = bar;
    cq_requester_id = rid; cq_tag = tag; cq_tc = tc; cq_lower_addr = la;
    cq_payload_dw_count = dw;
    tick();
    cq_valid = 1'b0;
    k = 1; nrq = 0; first_rq = 0;
    while (!s_axis_cc_tvalid && k < exp_k + 4) begin
      if (rd_req) begin
        nrq++;
        if (first_rq == 0) begin
          first_rq = k;
          chk("rd_addr", rd_addr, {addr[15:3], 3'b000});
        end
      end
      if (ok && k == 1 + lat) begin
        rd_data_valid = 1'b1; rd_data = data;
      end else begin
        rd_data_valid = 1'b0; rd_data = {$urandom, $urandom};
      end
      if (drop_at != 0 && k == drop_at) begin
        cq_valid = 1'b1; cq_type = 4'b0000; cq_tag = ~tag; exp_drops++;
      end else begin
        cq_valid = 1'b0;
      end
      tick();
      k++;
    end
    rd_data_valid = 1'b0; cq_valid = 1'b0;
    chk("tvalid_cycle", k, exp_k);
    chk("rd_req_count", nrq, ok ? 1 : 0);
    if (ok) chk("rd_req_cycle", first_rq, 1);
    if (!s_axis_cc_tvalid) begin
      user_reset = 1'b1; tick(); user_reset = 1'b0; exp_drops = 0;
      return;
    end
    got = s_axis_cc_tdata; gk = s_axis_cc_tkeep;
    chk("tdata", got, et);
    chk("tkeep", gk, ek);
    chk("tlast_tuser", {s_axis_cc_tlast, s_axis_cc_tuser}, {1'b1, 33'd0});
    chk("busy_send", busy, 1'b1);
    stable = 1'b1;
    for (int unsigned h = 0; h < hold; h++) begin
      rd_data_valid = 1'($urandom);
      rd_data = {$urandom, $urandom};
      tick();
      if (!s_axis_cc_tvalid || s_axis_cc_tdata !== got || s_axis_cc_tkeep !== gk) stable = 1'b0;
    end
    rd_data_valid = 1'b0;
    if (hold > 0) chk("hold_stable", stable, 1'b1);
    s_axis_cc_tready = 1'b1;
    if (drop_send) begin
      cq_valid = 1'b1; cq_type = 4'b0000; exp_drops++;
    end
    tick();
    s_axis_cc_tready = 1'b0; cq_valid = 1'b0;
    chk("after_hs", {s_axis_cc_tvalid, busy}, 2'b00);
    chk("drop_count", drop_count, exp_drops);
  endtask

  initial begin
    logic [255:0] got;
    logic [7:0] gk;
    bit extra;
    logic [10:0] rdw;
    logic [2:0] rbar;
    int unsigned rlat, rdrop;

    vt[0]  = '{11'd1, 16'h0104, 3'd0, 16'h0100, 8'h12, 64'hAABBCCDD_11223344, 3, 0, 0, 1'b0, 3'b000, 8'h0F, 32'hAABBCCDD};
    vt[1]  = '{11'd2, 16'h0008, 3'd0, 16'h0200, 8'h34, 64'hAABBCCDD_11223344, 2, 4, 0, 1'b0, 3'b000, 8'h1F, 32'h11223344};
    vt[2]  = '{11'd4, 16'h0010, 3'd0, 16'h0300, 8'h56, 64'hAABBCCDD_11223344, 2, 0, 0, 1'b0, 3'b001, 8'h07, 32'h0};
    vt[3]  = '{11'd1, 16'h0014, 3'd1, 16'h0301, 8'h57, 64'hAABBCCDD_11223344, 2, 0, 0, 1'b0, 3'b001, 8'h07, 32'h0};
    vt[4]  = '{11'd1, 16'h0020, 3'd0, 16'h0400, 8'h78, 64'hAABBCCDD_11223344, 1000, 3, 0, 1'b0, 3'b100, 8'h07, 32'h0};
    vt[5]  = '{11'd1, 16'h0030, 3'd0, 16'h0401, 8'h79, 64'h01234567_89ABCDEF, 1, 0, 0, 1'b0, 3'b000, 8'h0F, 32'h89ABCDEF};
    vt[6]  = '{11'd2, 16'h0044, 3'd0, 16'h0402, 8'h7A, 64'h01234567_89ABCDEF, 1, 0, 0, 1'b0, 3'b001, 8'h07, 32'h0};
    vt[7]  = '{11'd1, 16'h004C, 3'd0, 16'h0403, 8'h7B, 64'hDEADBEEF_CAFEF00D, 64, 1, 0, 1'b0, 3'b000, 8'h0F, 32'hDEADBEEF};
    vt[8]  = '{11'd1, 16'h0200, 3'd0, 16'h0500, 8'h90, 64'h55556666_77778888, 5, 0, 3, 1'b0, 3'b000, 8'h0F, 32'h77778888};
    vt[9]  = '{11'd0, 16'h0100, 3'd0, 16'h0501, 8'h91, 64'h55556666_77778888, 1, 0, 0, 1'b0, 3'b001, 8'h07, 32'h0};
    vt[10] = '{11'd2, 16'h0300, 3'd0, 16'h0502, 8'h92, 64'h0A0B0C0D_01020304, 1, 2, 0, 1'b1, 3'b000, 8'h1F, 32'h01020304};

    user_reset = 1'b1; cq_valid = 1'b0; cq_type = '0; cq_reg_addr = '0; cq_bar_id = '0;
    cq_requester_id = '0; cq_tag = '0; cq_tc = '0; cq_lower_addr = '0; cq_payload_dw_count = '0;
    rd_data = '0; rd_data_valid = 1'b0; s_axis_cc_tready = 1'b0;
    repeat (3) tick();
    chk("reset_tdata", s_axis_cc_tdata, 256'd0);
    chk("reset_ctrl", {s_axis_cc_tvalid, s_axis_cc_tkeep, s_axis_cc_tlast, rd_req, busy}, 12'd0);
    chk("reset_cnt", {drop_count, rd_addr}, 32'd0);
    user_reset = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) begin
      do_req(vt[i].dw, vt[i].addr, vt[i].bar, vt[i].rid, vt[i].tag, 3'(i), vt[i].addr[6:0],
             vt[i].data, vt[i].lat, vt[i].hold, vt[i].drop_at, vt[i].drop_send, got, gk);
      chk($sformatf("vec%0d_status", i), got[45:43], vt[i].e_status);
      chk($sformatf("vec%0d_keep", i), gk, vt[i].e_keep);
      chk($sformatf("vec%0d_dw0", i), got[127:96], vt[i].e_dw0);
      if (i == 8) begin
        chk("drops_after_rdwait", drop_count, 16'd1);
        cq_valid = 1'b1; cq_type = 4'b0001;
        tick();
        cq_valid = 1'b0; cq_type = 4'b0000;
        extra = 1'b0;
        for (int j = 0; j < 4; j++) begin
          if (s_axis_cc_tvalid || busy || rd_req) extra = 1'b1;
          tick();
        end
        chk("memwr_ignored", {extra, drop_count}, {1'b0, 16'd1});
      end
    end

    for (int r = 0; r < 40; r++) begin
      rdw  = ($urandom % 8 == 0) ? 11'($urandom) : 11'($urandom_range(0, 3));
      rbar = ($urandom % 4 == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      rlat = ($urandom % 10 == 0) ? 70 : $urandom_range(1, 8);
      rdrop = ($urandom % 3 == 0) ? $urandom_range(1, 2) : 0;
      do_req(rdw, 16'($urandom) & 16'hFFFC, rbar, 16'($urandom), 8'($urandom), 3'($urandom),
             7'($urandom), {$urandom, $urandom}, rlat, $urandom_range(0, 3), rdrop,
             1'($urandom % 4 == 0), got, gk);
    end

    cq_valid = 1'b1; cq_type = 4'b0000; cq_bar_id = 3'd2; cq_payload_dw_count = 11'd1;
    tick();
    cq_valid = 1'b0;
    chk("rst_seq_tvalid", s_axis_cc_tvalid, 1'b1);
    tick();
    user_reset = 1'b1;
    tick();
    user_reset = 1'b0;
    chk("rst_seq_state", {s_axis_cc_tvalid, busy, drop_count}, 18'd0);
    exp_drops = 0;
    s_axis_cc_tready = 1'b1;
    extra = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      if (s_axis_cc_tvalid) extra = 1'b1;
    end
    s_axis_cc_tready = 1'b0;
    chk("rst_seq_no_cpl", extra, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/cc_completer.md
Name: cc_completer

Overview:
- Completer-completion generator for PCIe memory reads: the transmit side of the completer path.
- Takes decoded read requests from the CQ descriptor channel and fetches 32/64-bit data from the register file.
- Builds one single-beat completion TLP (UltraScale CC descriptor format) and drives it onto s_axis_cc of the PCIe IP core.
- One outstanding request; requests arriving while busy are dropped and counted.

Parameters:
- DATA_WIDTH, 256, CC AXI-Stream data width (only 256 supported)
- BAR0_SIZE, 16, register byte-address width
- TIMEOUT_CYCLES, 64, max cycles waiting for rd_data_valid before completing with CA

Ports:
- user_clk  in  1  core clock
- user_reset  in  1  synchronous reset, active-high
- cq_valid  in  1  request descriptor valid (single beat)
- cq_type  in  4  request type; 4'b0000 = MemRd
- cq_reg_addr  in  BAR0_SIZE  DW-aligned byte address
- cq_bar_id  in  3  target BAR
- cq_requester_id  in  16  requester ID
- cq_tag  in  8  tag
- cq_tc  in  3  traffic class
- cq_lower_addr  in  7  lower byte address
- cq_payload_dw_count  in  11  requested DW count
- rd_req  out  1  one-cycle register read strobe
- rd_addr  out  BAR0_SIZE  8-byte-aligned read address ({addr[hi:3],3'b000})
- rd_data  in  64  read data
- rd_data_valid  in  1  read data valid (latency >= 1 after rd_req)
- s_axis_cc_tdata  out  DATA_WIDTH  completion TLP
- s_axis_cc_tkeep  out  DATA_WIDTH/32  DW enables
- s_axis_cc_tlast  out  1  always 1 with tvalid
- s_axis_cc_tuser  out  33  all zero
- s_axis_cc_tvalid  out  1  completion valid
- s_axis_cc_tready  in  1  core ready
- busy  out  1  state != IDLE
- drop_count  out  16  saturating count of dropped MemRd requests

Behaviour:
- Reset values: all outputs 0; state IDLE; drop_count 0. Reset mid-operation discards any pending completion; tvalid is low the cycle after user_reset is sampled high.
- Accept condition (IDLE only): cq_valid && cq_type==4'b0000. Non-MemRd types are ignored without counting.
- On accept, latch the descriptor fields and classify:
  - OK: bar_id==0 and (dw==1, or dw==2 with addr[2]==0).
  - UR: anything else.
- FSM states and transitions:
  - IDLE: OK -> RD_REQ; UR -> SEND (status 3'b001).
  - RD_REQ: rd_req=1 for exactly one cycle -> RD_WAIT; timer cleared.
  - RD_WAIT: rd_data_valid -> capture data, status 3'b000, -> SEND. Timer reaching TIMEOUT_CYCLES-1 without valid -> status 3'b100 (CA), -> SEND. Valid in the expiry cycle wins over the timeout. rd_data_valid outside RD_WAIT is ignored.
  - SEND: tvalid=1 with tdata/tkeep held stable until tready; handshake cycle -> IDLE.
- Descriptor fields (tdata):
  - [6:0] lower_addr; [9:8] 0.
  - [28:16] byte count: 4*dw for SC, 4 for UR/CA.
  - [42:32] dword count: dw for SC, 0 otherwise.
  - [45:43] status; [63:48] requester_id; [71:64] tag.
  - [88:72] 0 (completer ID disabled); [91:89] tc; [95:92] 0.
- Payload:
  - dw==1: [127:96] = addr[2] ? rd_data[63:32] : rd_data[31:0].
  - dw==2: [127:96] = rd_data[31:0], [159:128] = rd_data[63:32].
  - Unused tdata bits are 0.
- tkeep: 8'h0F (1 DW), 8'h1F (2 DW), 8'h07 (UR/CA).
- Latency, SC path: accept at t; rd_req at t+1; rd_data_valid at t+1+L; tvalid at t+2+L.
- Drop rule: an accepted-type request while busy (including the SEND handshake cycle) is dropped; drop_count increments and saturates at 16'hFFFF.

Test Plan:
- MemRd dw=1 addr=0x0104, tag=0x12, req_id=0x0100; rd_data=64'hAABBCCDD_11223344 with L=3 -> rd_req one cycle later, rd_addr=0x0100. tvalid at t+5 with tdata[127:96]=0xAABBCCDD, byte count 4, dword count 1, status 0, tkeep=8'h0F.
- MemRd dw=2 addr=0x0008, tready low 4 cycles -> tvalid held and tdata stable. Payload DWs 0x11223344 then 0xAABBCCDD, tkeep=8'h1F, one handshake, then IDLE.
- MemRd dw=4, and separately bar_id=1 -> no rd_req; completion with status 3'b001, byte count 4, dword count 0, tkeep=8'h07.
- rd_data_valid never asserted -> CA (3'b100) completion after TIMEOUT_CYCLES in RD_WAIT; a late rd_data_valid is ignored and the next request completes normally.
- Second MemRd during RD_WAIT plus one MemWr in IDLE -> drop_count=1, the MemWr is ignored, and only the first completion is emitted.
- user_reset asserted in SEND with tready low -> tvalid 0 next cycle, busy 0, drop_count 0, no completion emitted afterward.
